// File: rtl/hazard_ctrl_np.sv
// hazard_ctrl_np: pipeline hazard controller.
// Resolves EX-stage operand forwarding from MEM/WB, inserts load-use bubbles,
// holds the pipe while data memory is busy (with a timeout), and flushes the
// younger stages on a taken jump or branch. Also keeps saturating perf counters.
module hazard_ctrl_np #(
    parameter int XLEN  = 32,
    parameter int NRD   = 2,
    parameter int RA_W  = 5,
    parameter int TMO   = 255,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NRD*RA_W-1:0]  rf_ra_ex,
    input  logic [NRD-1:0]       rf_re_ex,
    input  logic                 rf_we_mem,
    input  logic [RA_W-1:0]      rf_wa_mem,
    input  logic [1:0]           rf_wd_sel_mem,
    input  logic [XLEN-1:0]      alu_ans_mem,
    input  logic [XLEN-1:0]      pc_add4_mem,
    input  logic [XLEN-1:0]      imm_mem,
    input  logic                 rf_we_wb,
    input  logic [RA_W-1:0]      rf_wa_wb,
    input  logic [XLEN-1:0]      rf_wd_wb,
    input  logic                 dm_req_mem,
    input  logic                 dm_ready,
    input  logic                 jal_ex,
    input  logic                 jalr_ex,
    input  logic                 br_ex,
    output logic [NRD-1:0]       rf_rd_fe,
    output logic [NRD*XLEN-1:0]  rf_rd_fd,
    output logic                 stall_if,
    output logic                 stall_id,
    output logic                 stall_ex,
    output logic                 stall_mem,
    output logic                 flush_id,
    output logic                 flush_ex,
    output logic                 flush_mem,
    output logic                 flush_wb,
    output logic                 err,
    output logic [CNT_W-1:0]     perf_stall,
    output logic [CNT_W-1:0]     perf_lu,
    output logic [CNT_W-1:0]     perf_flush
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_LU   = 2'd2;

    // The wait counter only needs to reach TMO-1: the TMO-th WAIT cycle is
    // the one that gives up on the memory.
    localparam int            TW       = (TMO < 2) ? 1 : $clog2(TMO + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_PC4 = 2'b01;
    localparam logic [1:0] SEL_MRD = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [TW-1:0]    waitCnt_q, waitCnt_d;
    logic             err_q;
    logic [CNT_W-1:0] perfStall_q, perfLu_q, perfFlush_q;

    logic [RA_W-1:0]  raPort [NRD];
    logic [NRD-1:0]   memHit;
    logic [NRD-1:0]   wbHit;
    logic             luRaw;
    logic             mwRaw;
    logic             timeout;
    logic             mwStall;
    logic             luStall;
    logic             rdFlush;

    // Per read port: does the MEM or WB stage write the register EX reads?
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            raPort[i] = rf_ra_ex[i*RA_W +: RA_W];
            memHit[i] = rf_re_ex[i] && (raPort[i] != '0) && rf_we_mem
                        && (rf_wa_mem == raPort[i]);
            wbHit[i]  = rf_re_ex[i] && (raPort[i] != '0) && rf_we_wb
                        && (rf_wa_wb == raPort[i]);
        end
    end

    // Select forward data; a MEM hit on load data cannot forward and flags load-use.
    always_comb begin
        rf_rd_fe = '0;
        rf_rd_fd = '0;
        luRaw    = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            if (memHit[i]) begin
                case (rf_wd_sel_mem)
                    SEL_ALU: begin
                        rf_rd_fe[i]               = 1'b1;
                        rf_rd_fd[i*XLEN +: XLEN]  = alu_ans_mem;
                    end
                    SEL_PC4: begin
                        rf_rd_fe[i]               = 1'b1;
                        rf_rd_fd[i*XLEN +: XLEN]  = pc_add4_mem;
                    end
                    SEL_MRD: begin
                        luRaw                     = 1'b1;
                    end
                    default: begin
                        rf_rd_fe[i]               = 1'b1;
                        rf_rd_fd[i*XLEN +: XLEN]  = imm_mem;
                    end
                endcase
            end else if (wbHit[i]) begin
                rf_rd_fe[i]              = 1'b1;
                rf_rd_fd[i*XLEN +: XLEN] = rf_wd_wb;
            end
        end
    end

    // Hazard priority: memory wait beats load-use beats redirect. A timed-out
    // access counts as complete, and a redirect waits until EX is free.
    always_comb begin
        mwRaw   = dm_req_mem & ~dm_ready;
        timeout = (state_q == ST_WAIT) && (waitCnt_q == TMO_LAST);
        mwStall = mwRaw & ~timeout;
        luStall = luRaw & ~mwStall & (state_q != ST_LU);
        rdFlush = (jal_ex | jalr_ex | br_ex) & ~mwStall & ~luStall;
    end

    // Stage control lines, held inactive while reset is asserted.
    always_comb begin
        stall_if  = rstn & (mwStall | luStall);
        stall_id  = rstn & (mwStall | luStall);
        stall_ex  = rstn & (mwStall | luStall);
        stall_mem = rstn & mwStall;
        flush_id  = rstn & rdFlush;
        flush_ex  = rstn & rdFlush;
        flush_mem = rstn & luStall;
        flush_wb  = rstn & mwStall;
    end

    // Control FSM next state and memory-wait cycle counter.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        case (state_q)
            ST_RUN: begin
                waitCnt_d = '0;
                if (mwRaw) begin
                    state_d = ST_WAIT;
                end else if (luStall) begin
                    state_d = ST_LU;
                end
            end
            ST_WAIT: begin
                if (!mwRaw || timeout) begin
                    state_d   = ST_RUN;
                    waitCnt_d = '0;
                end else begin
                    waitCnt_d = waitCnt_q + TW'(1);
                end
            end
            ST_LU: begin
                state_d   = ST_RUN;
                waitCnt_d = '0;
            end
            default: begin
                state_d   = ST_RUN;
                waitCnt_d = '0;
            end
        endcase
    end

    // FSM state, wait counter and the sticky timeout flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_RUN;
            waitCnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    // Saturating performance counters for stalls, bubbles and redirect flushes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perfStall_q <= '0;
            perfLu_q    <= '0;
            perfFlush_q <= '0;
        end else begin
            if ((mwStall | luStall) && (perfStall_q != {CNT_W{1'b1}})) begin
                perfStall_q <= perfStall_q + CNT_W'(1);
            end
            if (luStall && (perfLu_q != {CNT_W{1'b1}})) begin
                perfLu_q <= perfLu_q + CNT_W'(1);
            end
            if (rdFlush && (perfFlush_q != {CNT_W{1'b1}})) begin
                perfFlush_q <= perfFlush_q + CNT_W'(1);
            end
        end
    end

    assign err        = err_q;
    assign perf_stall = perfStall_q;
    assign perf_lu    = perfLu_q;
    assign perf_flush = perfFlush_q;

endmodule

// File: tb/tb_hazard_ctrl_np.sv
// tb_hazard_ctrl_np: directed and randomized checks of the hazard controller.
module tb_hazard_ctrl_np;

    localparam int XLEN  = 32;
    localparam int NRD   = 2;
    localparam int RA_W  = 5;
    localparam int TMO   = 4;
    localparam int CNT_W = 16;

    logic                clk;
    logic                rstn;
    logic [NRD*RA_W-1:0] rf_ra_ex;
    logic [NRD-1:0]      rf_re_ex;
    logic                rf_we_mem;
    logic [RA_W-1:0]     rf_wa_mem;
    logic [1:0]          rf_wd_sel_mem;
    logic [XLEN-1:0]     alu_ans_mem, pc_add4_mem, imm_mem;
    logic                rf_we_wb;
    logic [RA_W-1:0]     rf_wa_wb;
    logic [XLEN-1:0]     rf_wd_wb;
    logic                dm_req_mem, dm_ready;
    logic                jal_ex, jalr_ex, br_ex;
    logic [NRD-1:0]      rf_rd_fe;
    logic [NRD*XLEN-1:0] rf_rd_fd;
    logic                stall_if, stall_id, stall_ex, stall_mem;
    logic                flush_id, flush_ex, flush_mem, flush_wb;
    logic                err;
    logic [CNT_W-1:0]    perf_stall, perf_lu, perf_flush;

    int nVec = 0;
    int nErr = 0;
    int expStall = 0;
    int expLu    = 0;
    int expFlush = 0;

    hazard_ctrl_np #(
        .XLEN(XLEN), .NRD(NRD), .RA_W(RA_W), .TMO(TMO), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rstn(rstn),
        .rf_ra_ex(rf_ra_ex), .rf_re_ex(rf_re_ex),
        .rf_we_mem(rf_we_mem), .rf_wa_mem(rf_wa_mem), .rf_wd_sel_mem(rf_wd_sel_mem),
        .alu_ans_mem(alu_ans_mem), .pc_add4_mem(pc_add4_mem), .imm_mem(imm_mem),
        .rf_we_wb(rf_we_wb), .rf_wa_wb(rf_wa_wb), .rf_wd_wb(rf_wd_wb),
        .dm_req_mem(dm_req_mem), .dm_ready(dm_ready),
        .jal_ex(jal_ex), .jalr_ex(jalr_ex), .br_ex(br_ex),
        .rf_rd_fe(rf_rd_fe), .rf_rd_fd(rf_rd_fd),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
        .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem), .flush_wb(flush_wb),
        .err(err),
        .perf_stall(perf_stall), .perf_lu(perf_lu), .perf_flush(perf_flush)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idleInputs();
        rf_ra_ex      = '0;
        rf_re_ex      = '0;
        rf_we_mem     = 1'b0;
        rf_wa_mem     = '0;
        rf_wd_sel_mem = 2'b00;
        alu_ans_mem   = '0;
        pc_add4_mem   = '0;
        imm_mem       = '0;
        rf_we_wb      = 1'b0;
        rf_wa_wb      = '0;
        rf_wd_wb      = '0;
        dm_req_mem    = 1'b0;
        dm_ready      = 1'b0;
        jal_ex        = 1'b0;
        jalr_ex       = 1'b0;
        br_ex         = 1'b0;
    endtask

    // Moves to the next falling edge, where the bench drives and samples.
    task automatic nextCycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idleInputs();
        dm_req_mem = 1'b1;
        jal_ex     = 1'b1;
        nextCycle();
        #1;
        nVec++; if (stall_if !== 1'b0) begin nErr++; $display("[TB] FAIL reset_stall_if got %b exp 0", stall_if); end
        nVec++; if (stall_mem !== 1'b0 || flush_wb !== 1'b0) begin nErr++; $display("[TB] FAIL reset_mw_lines got %b%b exp 00", stall_mem, flush_wb); end
        nVec++; if (flush_id !== 1'b0 || flush_ex !== 1'b0) begin nErr++; $display("[TB] FAIL reset_flush got %b%b exp 00", flush_id, flush_ex); end
        nVec++; if (err !== 1'b0) begin nErr++; $display("[TB] FAIL reset_err got %b exp 0", err); end
        nVec++; if (perf_stall !== '0 || perf_lu !== '0 || perf_flush !== '0) begin nErr++; $display("[TB] FAIL reset_perf got %0d/%0d/%0d exp 0/0/0", perf_stall, perf_lu, perf_flush); end
        expStall = 0; expLu = 0; expFlush = 0;
        nextCycle();
        idleInputs();
        rstn = 1'b1;
        nextCycle();
    endtask

    task automatic test_forward();
        idleInputs();
        rf_re_ex    = 2'b11;
        rf_ra_ex    = {5'd5, 5'd5};
        rf_we_mem   = 1'b1;
        rf_wa_mem   = 5'd5;
        alu_ans_mem = 32'd7;
        pc_add4_mem = 32'h0000_1004;
        imm_mem     = 32'hFFFF_F000;
        #1;
        nVec++; if (rf_rd_fe !== 2'b11) begin nErr++; $display("[TB] FAIL fwd_mem_fe got %b exp 11", rf_rd_fe); end
        nVec++; if (rf_rd_fd !== {32'd7, 32'd7}) begin nErr++; $display("[TB] FAIL fwd_mem_fd got %h exp both 7", rf_rd_fd); end
        rf_we_wb = 1'b1; rf_wa_wb = 5'd5; rf_wd_wb = 32'd9;
        #1;
        nVec++; if (rf_rd_fd !== {32'd7, 32'd7}) begin nErr++; $display("[TB] FAIL fwd_mem_prio got %h exp both 7", rf_rd_fd); end
        rf_ra_ex = {5'd5, 5'd0};
        #1;
        nVec++; if (rf_rd_fe !== 2'b10 || rf_rd_fd[31:0] !== 32'd0) begin nErr++; $display("[TB] FAIL fwd_x0 got fe=%b fd0=%h exp fe=10 fd0=0", rf_rd_fe, rf_rd_fd[31:0]); end
        rf_ra_ex = {5'd5, 5'd5};
        rf_wd_sel_mem = 2'b01;
        #1;
        nVec++; if (rf_rd_fd[63:32] !== 32'h0000_1004) begin nErr++; $display("[TB] FAIL fwd_pc4 got %h exp 00001004", rf_rd_fd[63:32]); end
        rf_wd_sel_mem = 2'b11;
        #1;
        nVec++; if (rf_rd_fd[31:0] !== 32'hFFFF_F000) begin nErr++; $display("[TB] FAIL fwd_imm got %h exp fffff000", rf_rd_fd[31:0]); end
        rf_we_mem = 1'b0;
        #1;
        nVec++; if (rf_rd_fe !== 2'b11 || rf_rd_fd !== {32'd9, 32'd9}) begin nErr++; $display("[TB] FAIL fwd_wb got fe=%b fd=%h exp 11 / both 9", rf_rd_fe, rf_rd_fd); end
        rf_re_ex = 2'b00;
        #1;
        nVec++; if (rf_rd_fe !== 2'b00 || rf_rd_fd !== '0) begin nErr++; $display("[TB] FAIL fwd_re_off got fe=%b fd=%h exp 0", rf_rd_fe, rf_rd_fd); end
        idleInputs();
        nextCycle();
    endtask

    task automatic test_load_use();
        idleInputs();
        rf_re_ex      = 2'b01;
        rf_ra_ex      = {5'd0, 5'd6};
        rf_we_mem     = 1'b1;
        rf_wa_mem     = 5'd6;
        rf_wd_sel_mem = 2'b10;
        br_ex         = 1'b1;
        #1;
        nVec++; if ({stall_if, stall_id, stall_ex, stall_mem} !== 4'b1110) begin nErr++; $display("[TB] FAIL lu_stalls got %b exp 1110", {stall_if, stall_id, stall_ex, stall_mem}); end
        nVec++; if ({flush_id, flush_ex, flush_mem, flush_wb} !== 4'b0010) begin nErr++; $display("[TB] FAIL lu_flushes got %b exp 0010", {flush_id, flush_ex, flush_mem, flush_wb}); end
        nVec++; if (rf_rd_fe !== 2'b00) begin nErr++; $display("[TB] FAIL lu_fe got %b exp 00", rf_rd_fe); end
        expStall++; expLu++;
        nextCycle();
        nVec++; if (perf_lu !== CNT_W'(expLu)) begin nErr++; $display("[TB] FAIL lu_count got %0d exp %0d", perf_lu, expLu); end
        rf_we_mem = 1'b0;
        rf_we_wb  = 1'b1;
        rf_wa_wb  = 5'd6;
        rf_wd_wb  = 32'hCAFE_0006;
        #1;
        nVec++; if (rf_rd_fe !== 2'b01 || rf_rd_fd[31:0] !== 32'hCAFE_0006) begin nErr++; $display("[TB] FAIL lu_wb_fwd got fe=%b fd0=%h exp 01 cafe0006", rf_rd_fe, rf_rd_fd[31:0]); end
        nVec++; if (stall_if !== 1'b0 || flush_ex !== 1'b1) begin nErr++; $display("[TB] FAIL lu_release got stall=%b flush_ex=%b exp 0 1", stall_if, flush_ex); end
        expFlush++;
        nextCycle();
        idleInputs();
        nextCycle();
        nVec++; if (perf_stall !== CNT_W'(expStall) || perf_flush !== CNT_W'(expFlush)) begin nErr++; $display("[TB] FAIL lu_perf got %0d/%0d exp %0d/%0d", perf_stall, perf_flush, expStall, expFlush); end
    endtask

    task automatic test_mem_wait();
        idleInputs();
        dm_req_mem = 1'b1;
        br_ex      = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            nVec++; if ({stall_if, stall_id, stall_ex, stall_mem} !== 4'b1111) begin nErr++; $display("[TB] FAIL mw_stall c%0d got %b exp 1111", c, {stall_if, stall_id, stall_ex, stall_mem}); end
            nVec++; if ({flush_id, flush_ex, flush_mem, flush_wb} !== 4'b0001) begin nErr++; $display("[TB] FAIL mw_flush c%0d got %b exp 0001", c, {flush_id, flush_ex, flush_mem, flush_wb}); end
            expStall++;
            nextCycle();
        end
        dm_ready = 1'b1;
        #1;
        nVec++; if ({stall_if, stall_mem, flush_wb} !== 3'b000) begin nErr++; $display("[TB] FAIL mw_release got %b exp 000", {stall_if, stall_mem, flush_wb}); end
        nVec++; if (flush_id !== 1'b1 || flush_ex !== 1'b1) begin nErr++; $display("[TB] FAIL mw_held_redirect got %b%b exp 11", flush_id, flush_ex); end
        expFlush++;
        nextCycle();
        idleInputs();
        nextCycle();
        nVec++; if (perf_stall !== CNT_W'(expStall) || perf_flush !== CNT_W'(expFlush)) begin nErr++; $display("[TB] FAIL mw_perf got %0d/%0d exp %0d/%0d", perf_stall, perf_flush, expStall, expFlush); end
        nVec++; if (err !== 1'b0) begin nErr++; $display("[TB] FAIL mw_no_err got %b exp 0", err); end
    endtask

    // Memory never answers: TMO stalled cycles, then release with err set.
    task automatic waitUntilTimeout(input string tag);
        dm_req_mem = 1'b1;
        dm_ready   = 1'b0;
        for (int c = 0; c < TMO; c++) begin
            #1;
            nVec++; if (stall_mem !== 1'b1 || stall_if !== 1'b1) begin nErr++; $display("[TB] FAIL %s_stall c%0d got %b%b exp 11", tag, c, stall_if, stall_mem); end
            expStall++;
            nextCycle();
        end
        #1;
        nVec++; if (stall_mem !== 1'b0 || stall_if !== 1'b0) begin nErr++; $display("[TB] FAIL %s_release got %b%b exp 00", tag, stall_if, stall_mem); end
        nextCycle();
        dm_req_mem = 1'b0;
        #1;
        nVec++; if (err !== 1'b1) begin nErr++; $display("[TB] FAIL %s_err got %b exp 1", tag, err); end
        nVec++; if (stall_if !== 1'b0) begin nErr++; $display("[TB] FAIL %s_after got %b exp 0", tag, stall_if); end
        nextCycle();
    endtask

    task automatic test_timeout();
        idleInputs();
        #1;
        nVec++; if (err !== 1'b0) begin nErr++; $display("[TB] FAIL tmo_pre_err got %b exp 0", err); end
        waitUntilTimeout("tmo");
        nVec++; if (err !== 1'b1) begin nErr++; $display("[TB] FAIL tmo_sticky got %b exp 1", err); end
        nVec++; if (perf_stall !== CNT_W'(expStall)) begin nErr++; $display("[TB] FAIL tmo_perf got %0d exp %0d", perf_stall, expStall); end
    endtask

    task automatic test_reset_mid_wait();
        idleInputs();
        dm_req_mem = 1'b1;
        nextCycle();
        nextCycle();
        rstn = 1'b0;
        #1;
        nVec++; if ({stall_if, stall_id, stall_ex, stall_mem, flush_wb} !== 5'b0) begin nErr++; $display("[TB] FAIL rst_wait_lines got %b exp 00000", {stall_if, stall_id, stall_ex, stall_mem, flush_wb}); end
        nVec++; if (err !== 1'b0) begin nErr++; $display("[TB] FAIL rst_wait_err got %b exp 0", err); end
        nVec++; if (perf_stall !== '0 || perf_lu !== '0 || perf_flush !== '0) begin nErr++; $display("[TB] FAIL rst_wait_perf got %0d/%0d/%0d exp 0", perf_stall, perf_lu, perf_flush); end
        expStall = 0; expLu = 0; expFlush = 0;
        nextCycle();
        rstn = 1'b1;
        waitUntilTimeout("rst_tmo");
        nVec++; if (perf_stall !== CNT_W'(expStall)) begin nErr++; $display("[TB] FAIL rst_tmo_perf got %0d exp %0d", perf_stall, expStall); end
    endtask

    // Random forwarding/redirect traffic against a rule-level model; memory idle.
    task automatic test_random();
        bit prevBubble = 1'b0;
        for (int n = 0; n < 300; n++) begin
            logic [NRD-1:0]      expFe;
            logic [NRD*XLEN-1:0] expFd;
            bit                  luHit;
            bit                  redirect;
            idleInputs();
            rf_re_ex      = NRD'($urandom);
            for (int p = 0; p < NRD; p++) rf_ra_ex[p*RA_W +: RA_W] = RA_W'($urandom_range(0, 3));
            rf_we_mem     = prevBubble ? 1'b0 : 1'($urandom);
            rf_wa_mem     = RA_W'($urandom_range(0, 3));
            rf_wd_sel_mem = 2'($urandom);
            alu_ans_mem   = $urandom;
            pc_add4_mem   = $urandom;
            imm_mem       = $urandom;
            rf_we_wb      = 1'($urandom);
            rf_wa_wb      = RA_W'($urandom_range(0, 3));
            rf_wd_wb      = $urandom;
            jal_ex        = ($urandom_range(0, 7) == 0);
            jalr_ex       = ($urandom_range(0, 7) == 0);
            br_ex         = ($urandom_range(0, 5) == 0);
            expFe = '0; expFd = '0; luHit = 1'b0;
            for (int p = 0; p < NRD; p++) begin
                logic [RA_W-1:0] a;
                a = rf_ra_ex[p*RA_W +: RA_W];
                if (rf_re_ex[p] && a != 0 && rf_we_mem && rf_wa_mem == a) begin
                    if (rf_wd_sel_mem == 2'b10) luHit = 1'b1;
                    else begin
                        expFe[p] = 1'b1;
                        expFd[p*XLEN +: XLEN] = (rf_wd_sel_mem == 2'b00) ? alu_ans_mem :
                                                (rf_wd_sel_mem == 2'b01) ? pc_add4_mem : imm_mem;
                    end
                end else if (rf_re_ex[p] && a != 0 && rf_we_wb && rf_wa_wb == a) begin
                    expFe[p] = 1'b1;
                    expFd[p*XLEN +: XLEN] = rf_wd_wb;
                end
            end
            redirect = (jal_ex || jalr_ex || br_ex) && !luHit;
            #1;
            nVec++; if (rf_rd_fe !== expFe || rf_rd_fd !== expFd) begin nErr++; $display("[TB] FAIL rnd_fwd n%0d got fe=%b fd=%h exp fe=%b fd=%h", n, rf_rd_fe, rf_rd_fd, expFe, expFd); end
            nVec++; if ({stall_if, stall_ex, stall_mem, flush_mem} !== {luHit, luHit, 1'b0, luHit}) begin nErr++; $display("[TB] FAIL rnd_lu n%0d got %b exp %b", n, {stall_if, stall_ex, stall_mem, flush_mem}, {luHit, luHit, 1'b0, luHit}); end
            nVec++; if ({flush_id, flush_ex, flush_wb} !== {redirect, redirect, 1'b0}) begin nErr++; $display("[TB] FAIL rnd_rd n%0d got %b exp %b", n, {flush_id, flush_ex, flush_wb}, {redirect, redirect, 1'b0}); end
            if (luHit) begin expStall++; expLu++; end
            if (redirect) expFlush++;
            prevBubble = luHit;
            nextCycle();
        end
        idleInputs();
        nextCycle();
        nVec++; if (perf_stall !== CNT_W'(expStall) || perf_lu !== CNT_W'(expLu) || perf_flush !== CNT_W'(expFlush)) begin nErr++; $display("[TB] FAIL rnd_perf got %0d/%0d/%0d exp %0d/%0d/%0d", perf_stall, perf_lu, perf_flush, expStall, expLu, expFlush); end
    endtask

    // Runs every scenario in order and prints the summary.
    initial begin
        rstn = 1'b0;
        idleInputs();
        test_reset();
        test_forward();
        test_load_use();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got running exp finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule
